mem_responder: RTL and testbench

// - Memory-side responder for the control unit's memory handshake: the control unit raises MFA
//   (memory function activate) and waits in its fetch/load/store states until this block raises MOC.
// - Holds a byte-addressed, big-endian RAM and performs word, halfword and byte reads and writes.
// - Sits between the datapath MAR/MDR and the control unit's MOC input.

---
 rtl/mem_responder_pkg.sv | 60 ++++++
 rtl/mem_responder_if.sv | 15 +
 rtl/mem_responder_byte_lane_ram.sv | 39 +++
 rtl/mem_responder.sv | 130 +++++++++++++
 tb/tb_mem_responder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared encodings and lane helpers for the memory responder.
// Big-endian: byte offset 0 of a word lives in bits [31:24].
package memif_pkg;

   localparam logic [1:0] DT_BYTE = 2'b00;
   localparam logic [1:0] DT_HALF = 2'b01;
   localparam logic [1:0] DT_WORD = 2'b10;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_DONE = 2'b10
   } state_e;

   // Byte offset inside the word after alignment; the reserved code behaves as word.
   function automatic logic [1:0] align_lo(input logic [1:0] dt, input logic [1:0] lo);
      case (dt)
         DT_BYTE: align_lo = lo;
         DT_HALF: align_lo = {lo[1], 1'b0};
         default: align_lo = 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] dt, input logic [1:0] lo);
      case (dt)
         DT_BYTE: lane_mask = 4'b0001 << lo;
         DT_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   // Replicate narrow write data so every enabled lane sees its big-endian byte.
   function automatic logic [31:0] pack_wr(input logic [1:0] dt, input logic [31:0] d);
      case (dt)
         DT_BYTE: pack_wr = {4{d[7:0]}};
         DT_HALF: pack_wr = {2{d[15:0]}};
         default: pack_wr = d;
      endcase
   endfunction

   function automatic logic [31:0] fmt_read(input logic [1:0] dt, input logic [1:0] lo,
                                           input logic [31:0] w);
      case (dt)
         DT_BYTE: begin
            case (lo)
               2'd0:    fmt_read = {24'b0, w[31:24]};
               2'd1:    fmt_read = {24'b0, w[23:16]};
               2'd2:    fmt_read = {24'b0, w[15:8]};
               default: fmt_read = {24'b0, w[7:0]};
            endcase
         end
         DT_HALF: fmt_read = lo[1] ? {16'b0, w[15:0]} : {16'b0, w[31:16]};
         default: fmt_read = w;
      endcase
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// MFA/MOC memory handshake between the control unit/datapath (master) and the responder (slave).
// MFA is level-held until MOC; four-phase, so MFA must return low between requests.
interface mem_responder_if #(parameter int ADDR_W = 8);
   logic              MFA;
   logic              RW;
   logic [1:0]        DT;
   logic [ADDR_W-1:0] ADDR;
   logic [31:0]       DATA_IN;
   logic [31:0]       DATA_OUT;
   logic              MOC;
   logic              BUSY;

   modport master (output MFA, RW, DT, ADDR, DATA_IN, input DATA_OUT, MOC, BUSY);
   modport slave  (input MFA, RW, DT, ADDR, DATA_IN, output DATA_OUT, MOC, BUSY);
endinterface

// File: rtl/mem_responder_byte_lane_ram.sv
// Four byte-wide RAM lanes sharing one row address, per-lane write enable, registered word read.
// One-cycle read latency; no backpressure, accepts an access every cycle.
module byte_lane_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              rd_clr,
   input  logic [ADDR_W-3:0] row,
   input  logic [3:0]        wr_en,
   input  logic [31:0]       wr_dat,
   input  logic              rd_en,
   output logic [31:0]       rd_dat
);

   localparam int DEPTH = 2 ** (ADDR_W - 2);

   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q;

      always_ff @(posedge CLK) begin
         if (wr_en[i]) begin
            mem[row] <= wr_dat[31-8*i -: 8];
         end
      end

      // Only the read register is cleared; array contents survive reset.
      always_ff @(posedge CLK) begin
         if (rd_clr) begin
            q <= 8'h00;
         end else if (rd_en) begin
            q <= mem[row];
         end
      end

      assign rd_dat[31-8*i -: 8] = q;
   end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: captures an MFA request, waits LATENCY cycles, performs one RAM access, raises MOC.
// MOC arrives LATENCY+1 cycles after request; held while MFA stays high, released one cycle after MFA drops.
module mem_responder
   import memif_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic             CLK,
   input  logic             CLR,
   mem_responder_if.slave   bus
);

   localparam bit         ZERO_LAT = (LATENCY == 0);
   localparam logic [3:0] CNT_INIT = ZERO_LAT ? 4'd0 : 4'(LATENCY - 1);

   state_e            state;
   logic [3:0]        cnt;
   logic              cap_rw;
   logic [1:0]        cap_dt;
   logic [ADDR_W-1:0] cap_addr;
   logic [31:0]       cap_dat;
   logic              moc_q;
   logic              busy_q;
   logic [1:0]        last_dt;
   logic [1:0]        last_lo;

   logic              req_rw;
   logic [1:0]        req_dt;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_dat;
   logic [1:0]        lo;
   logic              access;
   logic              rd_en;
   logic [3:0]        wr_en;
   logic [31:0]       rd_dat;

   // On the capture edge the live inputs are the request; afterwards the captured copy is.
   always_comb begin
      req_rw   = cap_rw;
      req_dt   = cap_dt;
      req_addr = cap_addr;
      req_dat  = cap_dat;
      if (state == S_IDLE) begin
         req_rw   = bus.RW;
         req_dt   = bus.DT;
         req_addr = bus.ADDR;
         req_dat  = bus.DATA_IN;
      end
   end

   assign lo     = align_lo(req_dt, req_addr[1:0]);
   assign access = CLR && (((state == S_IDLE) && bus.MFA && ZERO_LAT) ||
                           ((state == S_WAIT) && (cnt == 4'd0)));
   assign rd_en  = access && (req_rw == RW_READ);
   assign wr_en  = (access && (req_rw == RW_WRITE)) ? lane_mask(req_dt, lo) : 4'b0000;

   byte_lane_ram #(.ADDR_W(ADDR_W)) u_ram (
      .CLK    (CLK),
      .rd_clr (!CLR),
      .row    (req_addr[ADDR_W-1:2]),
      .wr_en  (wr_en),
      .wr_dat (pack_wr(req_dt, req_dat)),
      .rd_en  (rd_en),
      .rd_dat (rd_dat)
   );

   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         moc_q    <= 1'b0;
         busy_q   <= 1'b0;
         cap_rw   <= RW_READ;
         cap_dt   <= DT_WORD;
         cap_addr <= '0;
         cap_dat  <= 32'h0;
         last_dt  <= DT_WORD;
         last_lo  <= 2'b00;
      end else begin
         if (rd_en) begin
            last_dt <= req_dt;
            last_lo <= lo;
         end
         case (state)
            S_IDLE: begin
               if (bus.MFA) begin
                  cap_rw   <= bus.RW;
                  cap_dt   <= bus.DT;
                  cap_addr <= bus.ADDR;
                  cap_dat  <= bus.DATA_IN;
                  busy_q   <= 1'b1;
                  if (ZERO_LAT) begin
                     state <= S_DONE;
                     moc_q <= 1'b1;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  state <= S_DONE;
                  moc_q <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_DONE: begin
               if (!bus.MFA) begin
                  state  <= S_IDLE;
                  moc_q  <= 1'b0;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= S_IDLE;
               moc_q  <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.DATA_OUT = fmt_read(last_dt, last_lo, rd_dat);
   assign bus.MOC      = moc_q;
   assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Two responders (LATENCY 2 and 0) driven by directed steps then random requests,
// checked against a byte-array big-endian memory model.
module tb_mem_responder;
   import memif_pkg::*;

   localparam int LIM = 40;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        clr  [2];
   logic        mfa  [2];
   logic        rw   [2];
   logic [1:0]  dt   [2];
   logic [7:0]  addr [2];
   logic [31:0] din  [2];
   logic [31:0] dout_o [2];
   logic        moc_o  [2];
   logic        busy_o [2];

   mem_responder_if #(.ADDR_W(8)) ifa ();
   mem_responder_if #(.ADDR_W(8)) ifb ();

   assign ifa.MFA = mfa[0];  assign ifa.RW = rw[0];  assign ifa.DT = dt[0];
   assign ifa.ADDR = addr[0]; assign ifa.DATA_IN = din[0];
   assign ifb.MFA = mfa[1];  assign ifb.RW = rw[1];  assign ifb.DT = dt[1];
   assign ifb.ADDR = addr[1]; assign ifb.DATA_IN = din[1];
   assign dout_o[0] = ifa.DATA_OUT; assign moc_o[0] = ifa.MOC; assign busy_o[0] = ifa.BUSY;
   assign dout_o[1] = ifb.DATA_OUT; assign moc_o[1] = ifb.MOC; assign busy_o[1] = ifb.BUSY;

   mem_responder #(.ADDR_W(8), .LATENCY(2)) dut_a (.CLK(CLK), .CLR(clr[0]), .bus(ifa));
   mem_responder #(.ADDR_W(8), .LATENCY(0)) dut_b (.CLK(CLK), .CLR(clr[1]), .bus(ifb));

   int          vectors = 0;
   int          miscompares = 0;
   int          lat [2] = '{2, 0};
   logic [7:0]  mem_m [2][256];
   logic [31:0] last_out [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference read straight from the byte array, big-endian.
   function automatic logic [31:0] mref(input int d, input logic [1:0] t, input logic [7:0] a);
      logic [7:0] b;
      if (t == DT_BYTE) return {24'b0, mem_m[d][a]};
      if (t == DT_HALF) begin
         b = a & 8'hFE;
         return {16'b0, mem_m[d][b], mem_m[d][b + 8'd1]};
      end
      b = a & 8'hFC;
      return {mem_m[d][b], mem_m[d][b + 8'd1], mem_m[d][b + 8'd2], mem_m[d][b + 8'd3]};
   endfunction

   task automatic mwrite(input int d, input logic [1:0] t, input logic [7:0] a, input logic [31:0] v);
      logic [7:0] b;
      if (t == DT_BYTE) mem_m[d][a] = v[7:0];
      else if (t == DT_HALF) begin
         b = a & 8'hFE;
         mem_m[d][b] = v[15:8]; mem_m[d][b + 8'd1] = v[7:0];
      end else begin
         b = a & 8'hFC;
         mem_m[d][b] = v[31:24]; mem_m[d][b + 8'd1] = v[23:16];
         mem_m[d][b + 8'd2] = v[15:8]; mem_m[d][b + 8'd3] = v[7:0];
      end
   endtask

   task automatic txn(input int d, input logic rw_i, input logic [1:0] dt_i, input logic [7:0] a,
                      input logic [31:0] wd, input int hold, input bit drop_wait,
                      input bit scramble, output logic [31:0] dout);
      int first;
      int high;
      logic [31:0] r;
      @(negedge CLK);
      mfa[d] = 1'b1; rw[d] = rw_i; dt[d] = dt_i; addr[d] = a; din[d] = wd;
      first = 0;
      for (int c = 1; c <= LIM && first == 0; c++) begin
         @(negedge CLK);
         if (c == 1) begin
            check("busy_in_flight", 32'(busy_o[d]), 32'd1);
            if (scramble) begin
               r = $urandom;
               rw[d] = r[0]; dt[d] = r[2:1]; addr[d] = r[10:3];
               din[d] = $urandom;
            end
            if (drop_wait) mfa[d] = 1'b0;
         end
         if (moc_o[d]) first = c;
      end
      check("moc_latency", 32'(first), 32'(lat[d] + 1));
      if (rw_i == RW_WRITE) mwrite(d, dt_i, a, wd);
      else last_out[d] = mref(d, dt_i, a);
      if (drop_wait) begin
         @(negedge CLK);
         check("moc_pulse_end", 32'(moc_o[d]), 32'd0);
      end else begin
         high = 0;
         repeat (hold) begin
            @(negedge CLK);
            if (moc_o[d]) high++;
         end
         check("moc_hold", 32'(high), 32'(hold));
         mfa[d] = 1'b0;
         @(negedge CLK);
         check("moc_release", 32'(moc_o[d]), 32'd0);
      end
      check("busy_after", 32'(busy_o[d]), 32'd0);
      check("data_out", dout_o[d], last_out[d]);
      dout = dout_o[d];
   endtask

   initial begin
      logic [31:0] dv;
      logic [31:0] r;
      int          d;
      for (int i = 0; i < 2; i++) begin
         clr[i] = 1'b0; mfa[i] = 1'b0; rw[i] = RW_READ; dt[i] = DT_WORD;
         addr[i] = 8'h00; din[i] = 32'h0; last_out[i] = 32'h0;
         for (int j = 0; j < 256; j++) mem_m[i][j] = 8'h00;
      end

      // Reset, then idle.
      repeat (2) @(negedge CLK);
      clr[0] = 1'b1; clr[1] = 1'b1;
      repeat (2) @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
         check("reset_moc", 32'(moc_o[i]), 32'd0);
         check("reset_busy", 32'(busy_o[i]), 32'd0);
         check("reset_dout", dout_o[i], 32'h0);
      end

      // Zero-fill both RAMs so every byte is known to the model.
      for (int i = 0; i < 2; i++)
         for (int w = 0; w < 64; w++)
            txn(i, RW_WRITE, DT_WORD, 8'(w * 4), 32'h0, 0, 1'b0, 1'b0, dv);

      // Word write/read, narrow reads, byte write (LATENCY 2).
      txn(0, RW_WRITE, DT_WORD, 8'h10, 32'hDEADBEEF, 1, 1'b0, 1'b0, dv);
      check("wr_keeps_dout", dv, 32'h0);
      txn(0, RW_READ, DT_WORD, 8'h10, 32'h0, 1, 1'b0, 1'b0, dv);
      check("word_rd_10", dv, 32'hDEADBEEF);
      txn(0, RW_READ, DT_BYTE, 8'h11, 32'h0, 0, 1'b0, 1'b0, dv);
      check("byte_rd_11", dv, 32'h000000AD);
      txn(0, RW_READ, DT_HALF, 8'h12, 32'h0, 0, 1'b0, 1'b0, dv);
      check("half_rd_12", dv, 32'h0000BEEF);
      txn(0, RW_READ, DT_HALF, 8'h13, 32'h0, 0, 1'b0, 1'b0, dv);
      check("half_rd_13", dv, 32'h0000BEEF);
      txn(0, RW_WRITE, DT_BYTE, 8'h13, 32'h12345677, 0, 1'b0, 1'b0, dv);
      check("byte_wr_keeps", dv, 32'h0000BEEF);
      txn(0, RW_READ, DT_WORD, 8'h10, 32'h0, 0, 1'b0, 1'b0, dv);
      check("word_rd_after_byte", dv, 32'hDEADBE77);

      // Handshake edges: long hold with scrambled inputs, drop in WAIT, zero latency.
      txn(0, RW_READ, DT_BYTE, 8'h10, 32'h0, 10, 1'b0, 1'b1, dv);
      check("hold10_single_rd", dv, 32'h000000DE);
      txn(0, RW_WRITE, DT_WORD, 8'h40, 32'h01020304, 10, 1'b0, 1'b1, dv);
      txn(0, RW_READ, DT_WORD, 8'h40, 32'h0, 0, 1'b1, 1'b0, dv);
      check("drop_in_wait_rd", dv, 32'h01020304);
      txn(1, RW_WRITE, DT_HALF, 8'hFF, 32'h0000A5C3, 0, 1'b0, 1'b0, dv);
      txn(1, RW_READ, DT_WORD, 8'hFC, 32'h0, 10, 1'b0, 1'b1, dv);
      check("lat0_half_wr", dv, 32'h0000A5C3);

      // Reset during WAIT aborts the write.
      @(negedge CLK);
      mfa[0] = 1'b1; rw[0] = RW_WRITE; dt[0] = DT_WORD; addr[0] = 8'h20; din[0] = 32'hCAFEF00D;
      @(negedge CLK);
      check("abort_busy", 32'(busy_o[0]), 32'd1);
      clr[0] = 1'b0; mfa[0] = 1'b0;
      @(negedge CLK);
      check("abort_moc", 32'(moc_o[0]), 32'd0);
      check("abort_busy_clr", 32'(busy_o[0]), 32'd0);
      check("abort_dout", dout_o[0], 32'h0);
      clr[0] = 1'b1; last_out[0] = 32'h0;
      repeat (3) @(negedge CLK);
      txn(0, RW_READ, DT_WORD, 8'h20, 32'h0, 0, 1'b0, 1'b0, dv);
      check("abort_no_write", dv, 32'h0);

      // Reset during DONE drops MOC next cycle.
      @(negedge CLK);
      mfa[0] = 1'b1; rw[0] = RW_READ; dt[0] = DT_WORD; addr[0] = 8'h10;
      repeat (3) @(negedge CLK);
      check("done_moc", 32'(moc_o[0]), 32'd1);
      clr[0] = 1'b0;
      @(negedge CLK);
      check("done_reset_moc", 32'(moc_o[0]), 32'd0);
      check("done_reset_dout", dout_o[0], 32'h0);
      clr[0] = 1'b1; mfa[0] = 1'b0; last_out[0] = 32'h0;
      @(negedge CLK);

      // Random traffic on both instances.
      for (int n = 0; n < 120; n++) begin
         r = $urandom;
         d = int'(r[0]);
         txn(d, r[1], r[3:2], r[11:4], $urandom, int'(r[13:12]),
             (d == 0) && (r[16:14] == 3'd0), 1'b1, dv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
